// File: rtl/regfile_write_arbiter.sv
// Owns the single register-file write port: sweeps init_val over lo..hi after reset or on
// request, then round-robin arbitrates four valid/ready writers onto registered port outputs.
module regfile_write_arbiter #(
    parameter int unsigned               addr_width = 5,
    parameter int unsigned               data_width = 64,
    parameter int unsigned               lo         = 0,
    parameter int unsigned               hi         = 31,
    parameter logic [data_width-1:0]     init_val   = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         init_req_i,
    input  logic [3:0]                   req_valid_i,
    input  logic [4*addr_width-1:0]      req_addr_i,
    input  logic [4*data_width-1:0]      req_data_i,
    output logic [3:0]                   req_ready_o,
    output logic [addr_width-1:0]        rf_addr_in_o,
    output logic [data_width-1:0]        rf_d_in_o,
    output logic                         rf_we_o,
    output logic                         init_done_o,
    output logic                         err_oor_o
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [addr_width-1:0] LO_A   = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A   = addr_width'(hi);
    localparam logic [31:0]           LO32   = 32'(lo);
    localparam logic [31:0]           SPAN32 = 32'(hi - lo);

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   cnt_q, cnt_d;
    logic [1:0]              ptr_q, ptr_d;
    logic                    rf_we_q, rf_we_d;
    logic [addr_width-1:0]   rf_addr_q, rf_addr_d;
    logic [data_width-1:0]   rf_data_q, rf_data_d;
    logic                    err_q, err_d;

    logic [3:0]              grant;
    logic [1:0]              gidx;
    logic [1:0]              scan_idx;
    logic                    found;
    logic [addr_width-1:0]   sel_addr;
    logic [data_width-1:0]   sel_data;
    logic [31:0]             sel_off;
    logic                    in_range;

    // Rotating-priority scan starting at ptr; INIT_REQ pre-empts every requester.
    always_comb begin
        grant    = '0;
        gidx     = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        if (state_q == S_RUN && !init_req_i) begin
            for (int k = 0; k < 4; k++) begin
                scan_idx = ptr_q + 2'(k);
                if (!found && req_valid_i[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    gidx            = scan_idx;
                    found           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (gidx == 2'(i)) begin
                sel_addr = req_addr_i[i*addr_width +: addr_width];
                sel_data = req_data_i[i*data_width +: data_width];
            end
        end
    end

    // Offset-from-lo test: addresses below lo wrap to a huge offset and fail the span check.
    assign sel_off  = 32'(sel_addr) - LO32;
    assign in_range = (sel_off <= SPAN32);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        err_d     = 1'b0;
        case (state_q)
            S_INIT: begin
                rf_we_d   = 1'b1;
                rf_addr_d = cnt_q;
                rf_data_d = init_val;
                if (cnt_q == HI_A) begin
                    state_d = S_RUN;
                    cnt_d   = LO_A;
                end else begin
                    cnt_d = cnt_q + addr_width'(1);
                end
            end
            S_RUN: begin
                if (init_req_i) begin
                    state_d = S_INIT;
                    cnt_d   = LO_A;
                end else if (found) begin
                    ptr_d = gidx + 2'd1;
                    if (in_range) begin
                        rf_we_d   = 1'b1;
                        rf_addr_d = sel_addr;
                        rf_data_d = sel_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_INIT;
            cnt_q     <= LO_A;
            ptr_q     <= 2'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            err_q     <= err_d;
        end
    end

    assign req_ready_o  = grant;
    assign rf_we_o      = rf_we_q;
    assign rf_addr_in_o = rf_addr_q;
    assign rf_d_in_o    = rf_data_q;
    assign err_oor_o    = err_q;
    assign init_done_o  = (state_q == S_RUN);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: instance A uses the full 0..31 range, instance B a narrowed 4..20 range for
// out-of-range handling. A small register-file model behind A checks write-to-read latency.
module tb_regfile_write_arbiter;

    localparam logic [63:0] INIT_A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [15:0] INIT_B = 16'h1234;

    logic clk;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic         a_rst_n, a_init;
    logic [3:0]   a_valid;
    logic [19:0]  a_addr;
    logic [255:0] a_data;
    logic [3:0]   a_ready;
    logic [4:0]   a_raddr;
    logic [63:0]  a_rdata;
    logic         a_we, a_done, a_err;

    logic         b_rst_n, b_init;
    logic [3:0]   b_valid;
    logic [19:0]  b_addr;
    logic [63:0]  b_data;
    logic [3:0]   b_ready;
    logic [4:0]   b_raddr;
    logic [15:0]  b_rdata;
    logic         b_we, b_done, b_err;

    logic [63:0]  mem [32];

    regfile_write_arbiter #(.init_val(INIT_A)) dut_a (
        .clk_i(clk), .rst_n_i(a_rst_n), .init_req_i(a_init),
        .req_valid_i(a_valid), .req_addr_i(a_addr), .req_data_i(a_data),
        .req_ready_o(a_ready), .rf_addr_in_o(a_raddr), .rf_d_in_o(a_rdata),
        .rf_we_o(a_we), .init_done_o(a_done), .err_oor_o(a_err)
    );

    regfile_write_arbiter #(.addr_width(5), .data_width(16), .lo(4), .hi(20), .init_val(INIT_B)) dut_b (
        .clk_i(clk), .rst_n_i(b_rst_n), .init_req_i(b_init),
        .req_valid_i(b_valid), .req_addr_i(b_addr), .req_data_i(b_data),
        .req_ready_o(b_ready), .rf_addr_in_o(b_raddr), .rf_d_in_o(b_rdata),
        .rf_we_o(b_we), .init_done_o(b_done), .err_oor_o(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (a_we) mem[a_raddr] <= a_rdata;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [4:0]  abase;
        logic [15:0] dtag;
        logic [3:0]  rdy;
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester i gets address abase+i and data {i, dtag}.
    task automatic set_a(input logic [3:0] v, input logic [4:0] abase, input logic [15:0] dtag);
        a_valid = v;
        for (int i = 0; i < 4; i++) begin
            a_addr[i*5 +: 5]   = abase + 5'(i);
            a_data[i*64 +: 64] = {44'h0, 4'(i), dtag};
        end
    endtask

    task automatic set_b(input int i, input logic [4:0] ad, input logic [15:0] d);
        b_addr[i*5 +: 5]   = ad;
        b_data[i*16 +: 16] = d;
    endtask

    task automatic sweep_a(input int n, input int ireq_at);
        for (int i = 0; i < n; i++) begin
            if (i == ireq_at) a_init = 1'b1;
            #1;
            chk("a_sweep_ready", 64'(a_ready), 64'd0);
            step();
            a_init = 1'b0;
            chk("a_sweep_we",   64'(a_we),    64'd1);
            chk("a_sweep_addr", 64'(a_raddr), 64'(i));
            chk("a_sweep_data", a_rdata,      INIT_A);
            chk("a_sweep_done", 64'(a_done),  64'(i == 31));
        end
    endtask

    initial begin
        tv[0]  = '{4'b1111, 5'd0,  16'h1000, 4'b0001, 1'b1, 5'd0,  64'h0000_0000_0000_1000};
        tv[1]  = '{4'b1111, 5'd0,  16'h1001, 4'b0010, 1'b1, 5'd1,  64'h0000_0000_0001_1001};
        tv[2]  = '{4'b1111, 5'd0,  16'h1002, 4'b0100, 1'b1, 5'd2,  64'h0000_0000_0002_1002};
        tv[3]  = '{4'b1111, 5'd0,  16'h1003, 4'b1000, 1'b1, 5'd3,  64'h0000_0000_0003_1003};
        tv[4]  = '{4'b1111, 5'd0,  16'h1004, 4'b0001, 1'b1, 5'd0,  64'h0000_0000_0000_1004};
        tv[5]  = '{4'b1111, 5'd0,  16'h1005, 4'b0010, 1'b1, 5'd1,  64'h0000_0000_0001_1005};
        tv[6]  = '{4'b1111, 5'd0,  16'h1006, 4'b0100, 1'b1, 5'd2,  64'h0000_0000_0002_1006};
        tv[7]  = '{4'b1111, 5'd0,  16'h1007, 4'b1000, 1'b1, 5'd3,  64'h0000_0000_0003_1007};
        tv[8]  = '{4'b0000, 5'd0,  16'h1008, 4'b0000, 1'b0, 5'd3,  64'h0000_0000_0003_1007};
        tv[9]  = '{4'b1010, 5'd8,  16'h2000, 4'b0010, 1'b1, 5'd9,  64'h0000_0000_0001_2000};
        tv[10] = '{4'b1010, 5'd8,  16'h2001, 4'b1000, 1'b1, 5'd11, 64'h0000_0000_0003_2001};
        tv[11] = '{4'b0001, 5'd16, 16'h3000, 4'b0001, 1'b1, 5'd16, 64'h0000_0000_0000_3000};
        tv[12] = '{4'b0001, 5'd16, 16'h3001, 4'b0001, 1'b1, 5'd16, 64'h0000_0000_0000_3001};
        tv[13] = '{4'b1100, 5'd28, 16'h4000, 4'b0100, 1'b1, 5'd30, 64'h0000_0000_0002_4000};
        tv[14] = '{4'b1100, 5'd28, 16'h4001, 4'b1000, 1'b1, 5'd31, 64'h0000_0000_0003_4001};
        tv[15] = '{4'b1100, 5'd30, 16'h4002, 4'b0100, 1'b1, 5'd0,  64'h0000_0000_0002_4002};
        tv[16] = '{4'b0001, 5'd0,  16'h5000, 4'b0001, 1'b1, 5'd0,  64'h0000_0000_0000_5000};

        a_rst_n = 1'b0; a_init = 1'b0; a_valid = '0; a_addr = '0; a_data = '0;
        b_rst_n = 1'b0; b_init = 1'b0; b_valid = '0; b_addr = '0; b_data = '0;
        step();
        step();
        chk("a_rst_we",    64'(a_we),    64'd0);
        chk("a_rst_addr",  64'(a_raddr), 64'd0);
        chk("a_rst_data",  a_rdata,      64'd0);
        chk("a_rst_err",   64'(a_err),   64'd0);
        chk("a_rst_done",  64'(a_done),  64'd0);
        chk("a_rst_ready", 64'(a_ready), 64'd0);
        chk("b_rst_we",    64'(b_we),    64'd0);
        chk("b_rst_data",  64'(b_rdata), 64'd0);
        chk("b_rst_done",  64'(b_done),  64'd0);

        // Power-on sweep of A
        a_rst_n = 1'b1;
        #1;
        chk("a_done_pre_sweep", 64'(a_done), 64'd0);
        sweep_a(32, -1);

        // Round-robin table
        for (int v = 0; v < 17; v++) begin
            set_a(tv[v].valid, tv[v].abase, tv[v].dtag);
            #1;
            chk($sformatf("tv%0d_ready", v), 64'(a_ready), 64'(tv[v].rdy));
            step();
            chk($sformatf("tv%0d_we", v),   64'(a_we),    64'(tv[v].we));
            chk($sformatf("tv%0d_addr", v), 64'(a_raddr), 64'(tv[v].addr));
            chk($sformatf("tv%0d_data", v), a_rdata,      tv[v].data);
            chk($sformatf("tv%0d_err", v),  64'(a_err),   64'd0);
            chk($sformatf("tv%0d_done", v), 64'(a_done),  64'd1);
        end

        // INIT_REQ with pending requests; ptr=1 must survive the sweep
        set_a(4'b0011, 5'd10, 16'h6000);
        a_init = 1'b1;
        #1;
        chk("ireq_ready", 64'(a_ready), 64'd0);
        step();
        a_init = 1'b0;
        chk("ireq_we",   64'(a_we),   64'd0);
        chk("ireq_done", 64'(a_done), 64'd0);
        sweep_a(32, 15);
        #1;
        chk("resume_ready0", 64'(a_ready), 64'b0010);
        step();
        chk("resume_addr0", 64'(a_raddr), 64'd11);
        chk("resume_data0", a_rdata,      64'h0000_0000_0001_6000);
        #1;
        chk("resume_ready1", 64'(a_ready), 64'b0001);
        step();
        chk("resume_we1",   64'(a_we),    64'd1);
        chk("resume_addr1", 64'(a_raddr), 64'd10);

        // Single requester 2, then read-back latency through the register-file model
        set_a(4'b0100, 5'd5, 16'h0);
        a_data[2*64 +: 64] = 64'h0000_0000_0000_ABCD;
        #1;
        chk("t3_ready", 64'(a_ready), 64'b0100);
        step();
        a_valid = '0;
        chk("t3_we",   64'(a_we),    64'd1);
        chk("t3_addr", 64'(a_raddr), 64'd7);
        chk("t3_data", a_rdata,      64'h0000_0000_0000_ABCD);
        chk("t3_mem_early", mem[7],  INIT_A);
        step();
        chk("t3_mem_read", mem[7],   64'h0000_0000_0000_ABCD);
        chk("t3_idle_we",  64'(a_we),    64'd0);
        chk("t3_idle_addr", 64'(a_raddr), 64'd7);

        // Instance B: narrowed range 4..20, out-of-range handling
        b_rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("b_sweep_ready", 64'(b_ready), 64'd0);
            step();
            chk("b_sweep_we",   64'(b_we),    64'd1);
            chk("b_sweep_addr", 64'(b_raddr), 64'(4 + i));
            chk("b_sweep_data", 64'(b_rdata), 64'(INIT_B));
            chk("b_sweep_done", 64'(b_done),  64'(i == 16));
        end
        set_b(1, 5'd25, 16'h2525);
        b_valid = 4'b0010;
        #1;
        chk("b_oor_hi_ready", 64'(b_ready), 64'b0010);
        step();
        chk("b_oor_hi_we",  64'(b_we),  64'd0);
        chk("b_oor_hi_err", 64'(b_err), 64'd1);
        set_b(1, 5'd5, 16'h0505);
        set_b(2, 5'd6, 16'h2222);
        b_valid = 4'b0110;
        #1;
        chk("b_next_ready", 64'(b_ready), 64'b0100);
        step();
        chk("b_next_err",  64'(b_err),   64'd0);
        chk("b_next_we",   64'(b_we),    64'd1);
        chk("b_next_addr", 64'(b_raddr), 64'd6);
        chk("b_next_data", 64'(b_rdata), 64'h2222);
        set_b(3, 5'd3, 16'h0303);
        b_valid = 4'b1000;
        #1;
        chk("b_oor_lo_ready", 64'(b_ready), 64'b1000);
        step();
        chk("b_oor_lo_we",  64'(b_we),  64'd0);
        chk("b_oor_lo_err", 64'(b_err), 64'd1);
        set_b(0, 5'd20, 16'h2020);
        b_valid = 4'b0001;
        #1;
        chk("b_hi_edge_ready", 64'(b_ready), 64'b0001);
        step();
        chk("b_hi_edge_we",   64'(b_we),    64'd1);
        chk("b_hi_edge_addr", 64'(b_raddr), 64'd20);
        chk("b_hi_edge_err",  64'(b_err),   64'd0);
        set_b(1, 5'd4, 16'h0404);
        b_valid = 4'b0010;
        #1;
        chk("b_lo_edge_ready", 64'(b_ready), 64'b0010);
        step();
        b_valid = '0;
        chk("b_lo_edge_we",   64'(b_we),    64'd1);
        chk("b_lo_edge_addr", 64'(b_raddr), 64'd4);
        chk("b_lo_edge_data", 64'(b_rdata), 64'h0404);
        step();
        chk("b_idle_we",   64'(b_we),    64'd0);
        chk("b_idle_err",  64'(b_err),   64'd0);
        chk("b_idle_addr", 64'(b_raddr), 64'd4);

        // Reset with a grant pending discards the write; then reset mid-sweep at entry 10
        set_a(4'b0001, 5'd12, 16'h7000);
        a_rst_n = 1'b0;
        step();
        a_valid = '0;
        chk("rst_flight_we",   64'(a_we),    64'd0);
        chk("rst_flight_addr", 64'(a_raddr), 64'd0);
        chk("rst_flight_data", a_rdata,      64'd0);
        chk("rst_flight_done", 64'(a_done),  64'd0);
        a_rst_n = 1'b1;
        sweep_a(10, -1);
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
        chk("rst_mid_we",   64'(a_we),    64'd0);
        chk("rst_mid_addr", 64'(a_raddr), 64'd0);
        chk("rst_mid_done", 64'(a_done),  64'd0);
        sweep_a(32, -1);
        step();
        chk("final_idle_we", 64'(a_we),   64'd0);
        chk("final_done",    64'(a_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
